// File: rtl/mmu_feeder.sv
// Upstream sequencer for the NxN systolic MMU: buffers one weight matrix and
// one activation matrix, then streams weight load, skewed wavefront and drain.
module mmu_feeder #(
    parameter int N            = 4,
    parameter int DW           = 8,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [$clog2(N)-1:0]  wr_row,
    input  logic [N*DW-1:0]       wr_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mmu_control,
    output logic [N*DW-1:0]       mmu_wt_arr,
    output logic [N*DW-1:0]       mmu_data_arr
);

    localparam int AW = $clog2(N);
    localparam int CW = $clog2(2*N + DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] W_LAST = CW'(N - 1);
    localparam logic [CW-1:0] F_LAST = CW'(2*N - 2);
    localparam logic [CW-1:0] D_LAST =
        CW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        FEED,
        DRAIN,
        DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [N*DW-1:0] r_w [N];
    logic [N*DW-1:0] r_x [N];

    logic            w_wr_ok;
    logic [N*DW-1:0] w_w0;
    logic [AW-1:0]   w_wi;
    logic [CW-1:0]   w_t;
    logic [N*DW-1:0] w_feed;

    assign w_wr_ok = wr_en && (r_state == IDLE);

    // Row 0 goes out on the start edge, so a same-edge write must bypass.
    assign w_w0 = (w_wr_ok && !wr_sel && wr_row == '0) ? wr_data : r_w[0];
    assign w_wi = AW'(r_cnt + CW'(1));
    assign w_t  = (r_state == FEED) ? r_cnt + CW'(1) : '0;

    // Wavefront slot t: lane k carries element (t-k) of activation row k.
    always_comb begin
        w_feed = '0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (int'(w_t) == k + j)
                    w_feed[k*DW +: DW] = r_x[k][j*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mmu_control  <= 1'b0;
            mmu_wt_arr   <= '0;
            mmu_data_arr <= '0;
            for (int k = 0; k < N; k++) begin
                r_w[k] <= '0;
                r_x[k] <= '0;
            end
        end else begin
            done         <= 1'b0;
            mmu_control  <= 1'b0;
            mmu_wt_arr   <= '0;
            mmu_data_arr <= '0;
            if (w_wr_ok) begin
                if (wr_sel)
                    r_x[wr_row] <= wr_data;
                else
                    r_w[wr_row] <= wr_data;
            end
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= LOAD_W;
                        r_cnt       <= '0;
                        busy        <= 1'b1;
                        mmu_control <= 1'b1;
                        mmu_wt_arr  <= w_w0;
                    end
                end
                LOAD_W: begin
                    if (r_cnt == W_LAST) begin
                        r_state      <= FEED;
                        r_cnt        <= '0;
                        mmu_data_arr <= w_feed;
                    end else begin
                        r_cnt       <= r_cnt + CW'(1);
                        mmu_control <= 1'b1;
                        mmu_wt_arr  <= r_w[w_wi];
                    end
                end
                FEED: begin
                    if (r_cnt == F_LAST) begin
                        r_cnt <= '0;
                        if (DRAIN_CYCLES == 0) begin
                            r_state <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end else begin
                        r_cnt        <= r_cnt + CW'(1);
                        mmu_data_arr <= w_feed;
                    end
                end
                DRAIN: begin
                    if (r_cnt == D_LAST) begin
                        r_state <= DONE;
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_feeder.sv
// Scoreboard bench for mmu_feeder: default build and a zero-drain build
// share one stimulus stream and are each checked against a matrix model.
module tb_mmu_feeder;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int L  = N * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_sel = 1'b0;
    logic [AW-1:0] wr_row = '0;
    logic [L-1:0]  wr_data = '0;
    logic          start = 1'b0;

    logic          busy0, done0, ctl0;
    logic [L-1:0]  wt0, dat0;
    logic          busy1, done1, ctl1;
    logic [L-1:0]  wt1, dat1;

    always #5 clk = ~clk;

    mmu_feeder #(.N(N), .DW(DW), .DRAIN_CYCLES(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_row(wr_row), .wr_data(wr_data), .start(start),
        .busy(busy0), .done(done0), .mmu_control(ctl0),
        .mmu_wt_arr(wt0), .mmu_data_arr(dat0)
    );

    mmu_feeder #(.N(N), .DW(DW), .DRAIN_CYCLES(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_row(wr_row), .wr_data(wr_data), .start(start),
        .busy(busy1), .done(done1), .mmu_control(ctl1),
        .mmu_wt_arr(wt1), .mmu_data_arr(dat1)
    );

    typedef struct packed {
        logic         ctl;
        logic [L-1:0] wt;
        logic [L-1:0] dat;
        logic         busy;
        logic         done;
    } out_t;

    out_t q0[$], q1[$], cap0[$], cap1[$];
    out_t c0, c1, x0, x1;

    logic [DW-1:0] mW [2][N][N];
    logic [DW-1:0] mX [2][N][N];
    int            m_left [2];

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    bit cap_en = 1'b0;

    logic [L-1:0] e_wt  [N];
    logic [L-1:0] e_dat [2*N-1];

    function automatic int drain_of(input int u);
        return (u == 0) ? 4 : 0;
    endfunction

    // Expected output j cycles into a sequence, from the buffered matrices.
    function automatic out_t exp_at(input int u, input int j);
        out_t o;
        int   t;
        o = '0;
        if (j < N) begin
            o.ctl  = 1'b1;
            o.busy = 1'b1;
            for (int k = 0; k < N; k++)
                o.wt[k*DW +: DW] = mW[u][j][k];
        end else if (j < 3*N - 1) begin
            t = j - N;
            o.busy = 1'b1;
            for (int k = 0; k < N; k++)
                if (t - k >= 0 && t - k < N)
                    o.dat[k*DW +: DW] = mX[u][k][t-k];
        end else if (j < 3*N - 1 + drain_of(u)) begin
            o.busy = 1'b1;
        end else begin
            o.done = 1'b1;
        end
        return o;
    endfunction

    task automatic check(input string nm, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got ctl=%0b wt=%h dat=%h busy=%0b done=%0b want ctl=%0b wt=%h dat=%h busy=%0b done=%0b",
                     nm, got.ctl, got.wt, got.dat, got.busy, got.done,
                     exp.ctl, exp.wt, exp.dat, exp.busy, exp.done);
        end
    endtask

    // Reference model: sequence timeline and buffer contents per build.
    initial forever begin
        @(posedge clk);
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                for (int r = 0; r < N; r++)
                    for (int k = 0; k < N; k++) begin
                        mW[u][r][k] = '0;
                        mX[u][r][k] = '0;
                    end
                m_left[u] = 0;
                if (u == 0) q0.delete();
                else q1.delete();
            end else if (m_left[u] == 0) begin
                if (wr_en)
                    for (int k = 0; k < N; k++) begin
                        if (wr_sel) mX[u][wr_row][k] = wr_data[k*DW +: DW];
                        else mW[u][wr_row][k] = wr_data[k*DW +: DW];
                    end
                if (start) begin
                    m_left[u] = 3*N - 1 + drain_of(u) + 1;
                    for (int j = 0; j < m_left[u]; j++) begin
                        if (u == 0) q0.push_back(exp_at(0, j));
                        else q1.push_back(exp_at(1, j));
                    end
                end
            end else begin
                m_left[u]--;
            end
        end
    end

    // Monitor: every cycle either pops an expected word or expects quiet.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            c0 = {ctl0, wt0, dat0, busy0, done0};
            c1 = {ctl1, wt1, dat1, busy1, done1};
            x0 = (q0.size() > 0) ? q0.pop_front() : '0;
            x1 = (q1.size() > 0) ? q1.pop_front() : '0;
            check("dut0_stream", c0, x0);
            check("dut1_stream", c1, x1);
            if (cap_en) begin
                if (busy0 || done0) cap0.push_back(c0);
                if (busy1 || done1) cap1.push_back(c1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input int row, input logic [L-1:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = AW'(row);
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_defaults();
        wr(1'b0, 0, 32'h05020304);
        wr(1'b0, 1, 32'h03010203);
        wr(1'b0, 2, 32'h07040102);
        wr(1'b0, 3, 32'h01020403);
        wr(1'b1, 0, 32'h00000201);
        wr(1'b1, 1, 32'h02010201);
        wr(1'b1, 2, 32'h01030101);
        wr(1'b1, 3, 32'h05040200);
    endtask

    task automatic set_default_exp();
        e_wt[0]  = 32'h05020304;
        e_wt[1]  = 32'h03010203;
        e_wt[2]  = 32'h07040102;
        e_wt[3]  = 32'h01020403;
        e_dat[0] = 32'h00000001;
        e_dat[1] = 32'h00000102;
        e_dat[2] = 32'h00010200;
        e_dat[3] = 32'h00010100;
        e_dat[4] = 32'h02030200;
        e_dat[5] = 32'h04010000;
        e_dat[6] = 32'h05000000;
    endtask

    // Captured run against literal vectors; 16 words default, 12 zero-drain.
    task automatic chk_run(input string nm);
        out_t e;
        checks++;
        if (cap0.size() != 16) begin
            errors++;
            $display("FAIL %s_len0: got %0d want 16", nm, cap0.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                e = '0;
                if (i < 4) begin
                    e.ctl = 1'b1; e.wt = e_wt[i]; e.busy = 1'b1;
                end else if (i < 11) begin
                    e.dat = e_dat[i-4]; e.busy = 1'b1;
                end else if (i < 15) begin
                    e.busy = 1'b1;
                end else begin
                    e.done = 1'b1;
                end
                check($sformatf("%s_d0_%0d", nm, i), cap0[i], e);
            end
        end
        checks++;
        if (cap1.size() != 12) begin
            errors++;
            $display("FAIL %s_len1: got %0d want 12", nm, cap1.size());
        end else begin
            e = '0; e.dat = e_dat[6]; e.busy = 1'b1;
            check($sformatf("%s_d1_last", nm), cap1[10], e);
            e = '0; e.done = 1'b1;
            check($sformatf("%s_d1_done", nm), cap1[11], e);
        end
    endtask

    task automatic cap_start();
        cap0.delete();
        cap1.delete();
        cap_en = 1'b1;
    endtask

    initial begin
        tick();
        mon_en = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();

        load_defaults();
        set_default_exp();
        cap_start();
        start = 1'b1; tick(); start = 1'b0;
        repeat (20) tick();
        cap_en = 1'b0;
        chk_run("run1");

        cap_start();
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b1;
        wr_row = '0; wr_data = 32'hffffffff;
        tick();
        start = 1'b0; wr_en = 1'b0;
        repeat (20) tick();
        cap_en = 1'b0;
        chk_run("busy_ignore");

        cap_start();
        start = 1'b1; tick(); start = 1'b0;
        repeat (20) tick();
        cap_en = 1'b0;
        chk_run("repeat");

        start = 1'b1; tick(); start = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        tick();
        for (int i = 0; i < N; i++) e_wt[i] = '0;
        for (int i = 0; i < 2*N-1; i++) e_dat[i] = '0;
        cap_start();
        start = 1'b1; tick(); start = 1'b0;
        repeat (20) tick();
        cap_en = 1'b0;
        chk_run("after_reset");

        load_defaults();
        set_default_exp();
        e_dat[2] = 32'h000a0200;
        e_dat[3] = 32'h000b0100;
        e_dat[4] = 32'h020c0200;
        e_dat[5] = 32'h040d0000;
        cap_start();
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b1;
        wr_row = 2'd2; wr_data = 32'h0d0c0b0a;
        tick();
        start = 1'b0; wr_en = 1'b0;
        repeat (15) tick();
        start = 1'b1; tick();
        cap_en = 1'b0;
        tick(); start = 1'b0;
        chk_run("wr_with_start");
        repeat (20) tick();

        for (int i = 0; i < 400; i++) begin
            rst_n   = ($urandom % 64) != 0;
            wr_en   = $urandom % 2;
            wr_sel  = $urandom % 2;
            wr_row  = AW'($urandom % N);
            wr_data = $urandom;
            start   = ($urandom % 6) == 0;
            tick();
        end
        rst_n = 1'b1; wr_en = 1'b0; start = 1'b0;
        repeat (25) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
